// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, with a single
// outstanding miss to the memory controller and flush-aware fill handling.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_to_ic_valid,
  input  logic [31:0] if_to_ic_pc,
  output logic        ic_to_if_ready,
  output logic [31:0] ic_to_if_inst,
  output logic        ic_to_mc_ready,
  output logic [31:0] ic_to_mc_pc,
  input  logic        mc_to_ic_ready,
  input  logic [31:0] mc_dout
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state;
  logic                    discard;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    hit, accept, fill;
  logic                    unused_lsb;

  assign req_idx  = if_to_ic_pc[INDEX_BITS+1:2];
  assign req_tag  = if_to_ic_pc[31:INDEX_BITS+2];
  // Fills use the latched miss address: the requester may change pc after a flush.
  assign fill_idx = ic_to_mc_pc[INDEX_BITS+1:2];
  assign fill_tag = ic_to_mc_pc[31:INDEX_BITS+2];
  assign unused_lsb = ^if_to_ic_pc[1:0];

  assign hit    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept = rdy_in && (state == S_IDLE) && if_to_ic_valid &&
                  !ic_to_if_ready && !clr_in;
  assign fill   = rdy_in && (state == S_WAIT) && mc_to_ic_ready;

  assign ic_to_mc_ready = (state == S_WAIT) && !mc_to_ic_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      discard        <= 1'b0;
      valid_q        <= '0;
      ic_to_if_ready <= 1'b0;
      ic_to_if_inst  <= '0;
      ic_to_mc_pc    <= '0;
    end else if (rdy_in) begin
      ic_to_if_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (hit) begin
              ic_to_if_ready <= 1'b1;
              ic_to_if_inst  <= data_mem[req_idx];
            end else begin
              ic_to_mc_pc <= {if_to_ic_pc[31:2], 2'b00};
              discard     <= 1'b0;
              state       <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (fill) begin
            valid_q[fill_idx] <= 1'b1;
            state             <= S_IDLE;
            if (!discard && !clr_in) begin
              ic_to_if_ready <= 1'b1;
              ic_to_if_inst  <= mc_dout;
            end
          end else if (clr_in) begin
            discard <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mc_dout;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: driver pushes expected instruction words,
// a negedge monitor pops and compares whenever a response pulse appears.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, if_to_ic_valid, mc_to_ic_ready;
  logic [31:0] if_to_ic_pc, mc_dout;
  logic        ic_to_if_ready, ic_to_mc_ready;
  logic [31:0] ic_to_if_inst, ic_to_mc_pc;

  icache #(.INDEX_BITS(6)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clr_in         (clr_in),
    .if_to_ic_valid (if_to_ic_valid),
    .if_to_ic_pc    (if_to_ic_pc),
    .ic_to_if_ready (ic_to_if_ready),
    .ic_to_if_inst  (ic_to_if_inst),
    .ic_to_mc_ready (ic_to_mc_ready),
    .ic_to_mc_pc    (ic_to_mc_pc),
    .mc_to_ic_ready (mc_to_ic_ready),
    .mc_dout        (mc_dout)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];
  logic [29:0] cached [int];   // line index -> word address currently held
  logic [31:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Static instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h00A0_0093;
      32'h0000_0200: return 32'h1234_5678;
      32'h0000_0300: return 32'hDEAD_BEEF;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always @(negedge clk_in) begin
    if (ic_to_if_ready && rdy_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got inst %h, want no response", ic_to_if_inst);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("resp_inst", ic_to_if_inst, mon_exp);
      end
    end
  end

  // clr_mode: 0 none, 1 flush pulse during WAIT, 2 flush together with fill
  task automatic fetch(input logic [31:0] pc, input int clr_mode, input bit stall);
    int          idx = int'(pc[7:2]);
    logic [29:0] wa  = pc[31:2];
    logic [31:0] fa  = {pc[31:2], 2'b00};
    bit          hit = cached.exists(idx) && (cached[idx] == wa);
    if_to_ic_pc    = pc;
    if_to_ic_valid = 1'b1;
    if (hit) exp_q.push_back(mem_word(fa));
    tick();
    if_to_ic_valid = 1'b0;
    chk("hit_resp_ready", {31'b0, ic_to_if_ready}, {31'b0, hit});
    if (hit) begin
      chk("hit_no_mc_req", {31'b0, ic_to_mc_ready}, 32'd0);
      tick();
      return;
    end
    chk("miss_mc_ready", {31'b0, ic_to_mc_ready}, 32'd1);
    chk("miss_mc_pc", ic_to_mc_pc, fa);
    repeat ($urandom_range(0, 2)) tick();
    if (stall) begin
      rdy_in = 1'b0;
      clr_in = 1'b1;
      mc_to_ic_ready = 1'b1;
      mc_dout = 32'hBAD0_BAD0;
      tick();
      mc_to_ic_ready = 1'b0;
      repeat (2) tick();
      rdy_in = 1'b1;
      clr_in = 1'b0;
      #1;
      chk("stall_mc_pc", ic_to_mc_pc, fa);
      chk("stall_mc_ready", {31'b0, ic_to_mc_ready}, 32'd1);
    end
    if (clr_mode == 1) begin
      clr_in = 1'b1;
      tick();
      clr_in = 1'b0;
    end
    chk("wait_no_resp", {31'b0, ic_to_if_ready}, 32'd0);
    mc_dout        = mem_word(fa);
    mc_to_ic_ready = 1'b1;
    if (clr_mode == 2) clr_in = 1'b1;
    #1;
    chk("mc_ready_drop_on_fill", {31'b0, ic_to_mc_ready}, 32'd0);
    if (clr_mode == 0) exp_q.push_back(mem_word(fa));
    tick();
    mc_to_ic_ready = 1'b0;
    clr_in         = 1'b0;
    cached[idx]    = wa;
    chk("fill_resp_ready", {31'b0, ic_to_if_ready}, {31'b0, clr_mode == 0});
    chk("idle_after_fill", {31'b0, ic_to_mc_ready}, 32'd0);
    tick();
    chk("resp_one_cycle", {31'b0, ic_to_if_ready}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] tg;
    logic [5:0]  ix;
    logic [1:0]  lo;
    int          tsel;
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; if_to_ic_valid = 1'b0;
    mc_to_ic_ready = 1'b0; if_to_ic_pc = '0; mc_dout = '0;
    repeat (2) tick();
    chk("rst_if_ready", {31'b0, ic_to_if_ready}, 32'd0);
    chk("rst_if_inst", ic_to_if_inst, 32'd0);
    chk("rst_mc_ready", {31'b0, ic_to_mc_ready}, 32'd0);
    chk("rst_mc_pc", ic_to_mc_pc, 32'd0);
    rst_in = 1'b0;
    tick();

    fetch(32'h100, 0, 1'b0);   // cold miss
    fetch(32'h100, 0, 1'b0);   // hit
    fetch(32'h200, 0, 1'b0);   // conflict on index 0
    fetch(32'h100, 0, 1'b0);   // evicted, misses again
    fetch(32'h300, 1, 1'b0);   // flushed miss
    fetch(32'h300, 0, 1'b0);   // now hits
    fetch(32'h140, 0, 1'b1);   // stalled miss
    fetch(32'h240, 2, 1'b0);   // flush coincident with fill
    fetch(32'h240, 0, 1'b0);

    // flush in IDLE blocks a would-be hit
    if_to_ic_pc = 32'h300; if_to_ic_valid = 1'b1; clr_in = 1'b1;
    tick();
    if_to_ic_valid = 1'b0; clr_in = 1'b0;
    chk("clr_idle_no_resp", {31'b0, ic_to_if_ready}, 32'd0);
    chk("clr_idle_no_req", {31'b0, ic_to_mc_ready}, 32'd0);
    tick();

    // asynchronous reset while a miss is outstanding
    if_to_ic_pc = 32'h104; if_to_ic_valid = 1'b1;
    tick();
    if_to_ic_valid = 1'b0;
    chk("pre_rst_mc_ready", {31'b0, ic_to_mc_ready}, 32'd1);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_mc_ready", {31'b0, ic_to_mc_ready}, 32'd0);
    chk("async_rst_mc_pc", ic_to_mc_pc, 32'd0);
    chk("async_rst_if_ready", {31'b0, ic_to_if_ready}, 32'd0);
    tick();
    rst_in = 1'b0;
    cached.delete();
    mc_dout = 32'hCAFE_F00D; mc_to_ic_ready = 1'b1;
    tick();
    mc_to_ic_ready = 1'b0;
    chk("stale_fill_ignored", {31'b0, ic_to_if_ready}, 32'd0);
    chk("stale_fill_no_req", {31'b0, ic_to_mc_ready}, 32'd0);
    fetch(32'h100, 0, 1'b0);   // misses after reset

    for (int i = 0; i < 200; i++) begin
      tsel = $urandom_range(0, 3);
      tg   = (tsel == 3) ? 24'hFF_FFFF : 24'(tsel);
      ix   = 6'($urandom_range(0, 63));
      lo   = 2'($urandom_range(0, 3));
      fetch({tg, ix, lo}, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0,
            ($urandom_range(0, 7) == 0));
    end

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL provide parameter INDEX_BITS, default 6, meaning log2 of line count (64 direct-mapped lines, one 32-bit word per line).
REQ-002 SHALL provide clk_in  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide rst_in  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide rdy_in  input  1  global enable; low freezes all state.
REQ-005 SHALL provide clr_in  input  1  pipeline flush (branch mispredict).
REQ-006 SHALL provide if_to_ic_valid  input  1  fetch request from fetch unit.
REQ-007 SHALL provide if_to_ic_pc  input  32  fetch address, held stable by requester until ic_to_if_ready or clr_in.
REQ-008 SHALL provide ic_to_if_ready  output  1  one-cycle pulse, instruction valid.
REQ-009 SHALL provide ic_to_if_inst  output  32  returned instruction word.
REQ-010 SHALL provide ic_to_mc_ready  output  1  fetch request to memory controller.
REQ-011 SHALL provide ic_to_mc_pc  output  32  word-aligned miss address.
REQ-012 SHALL provide mc_to_ic_ready  input  1  one-cycle pulse, fill word valid on mc_dout.
REQ-013 SHALL provide mc_dout  input  32  fill word, little-endian assembled by memory controller.

Function
REQ-014 SHALL decode address as index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
REQ-015 SHALL hold per line: valid bit, tag, 32-bit data.
REQ-016 SHALL implement states IDLE, WAIT (miss outstanding).
REQ-017 SHALL accept a request only when rdy_in=1, state=IDLE, if_to_ic_valid=1, ic_to_if_ready=0, clr_in=0.
REQ-018 On accepted hit SHALL register ic_to_if_ready=1, ic_to_if_inst=line data; latency 1 cycle; state stays IDLE.
REQ-019 On accepted miss SHALL latch {pc[31:2],2'b00} into ic_to_mc_pc, clear discard flag, go to WAIT.
REQ-020 SHALL drive ic_to_mc_ready combinationally = (state==WAIT) && !mc_to_ic_ready, so the controller never re-samples a completed request.
REQ-021 SHALL keep ic_to_mc_pc constant throughout WAIT.
REQ-022 In WAIT on mc_to_ic_ready=1 SHALL write line (valid=1, tag, mc_dout), return to IDLE, and, if discard flag clear, register ic_to_if_ready=1, ic_to_if_inst=mc_dout (miss-to-response 1 cycle after fill pulse).
REQ-023 SHALL ignore mc_to_ic_ready while IDLE.
REQ-024 clr_in in IDLE SHALL suppress acceptance and any ic_to_if_ready for that cycle's request.
REQ-025 clr_in in WAIT SHALL set discard flag; request stays asserted, fill still completes and updates the line, no ic_to_if_ready pulse.
REQ-026 clr_in SHALL NOT invalidate any line; instruction memory is static.
REQ-027 ic_to_if_ready SHALL deassert the cycle after any pulse (never high two consecutive enabled cycles).
REQ-028 rdy_in=0 SHALL freeze state, lines, registered outputs and discard flag; mc_to_ic_ready and clr_in are ignored while rdy_in=0.
REQ-029 Simultaneous clr_in and mc_to_ic_ready in WAIT SHALL fill the line and emit no response.

Reset
REQ-030 rst_in high SHALL immediately clear all valid bits, state=IDLE, discard=0, ic_to_if_ready=0, ic_to_if_inst=0, ic_to_mc_pc=0 (hence ic_to_mc_ready=0).
REQ-031 Reset mid-WAIT SHALL abandon the miss; any later fill pulse is ignored per REQ-023.

Verification
REQ-032 Cold miss: reset, request pc 0x00000100 -> ic_to_mc_ready=1, ic_to_mc_pc=0x100; fill pulse with mc_dout=0x00A00093 -> ic_to_mc_ready low same cycle, ic_to_if_ready pulse next cycle, inst 0x00A00093.
REQ-033 Hit: re-request 0x100 -> ic_to_if_ready next cycle with 0x00A00093, ic_to_mc_ready stays 0.
REQ-034 Conflict: request 0x200 (index 0, different tag), fill 0x12345678 -> returned; then 0x100 misses again.
REQ-035 Flush: request 0x300 miss, clr_in pulse in WAIT, fill 0xDEADBEEF -> no ic_to_if_ready; later 0x300 hits in 1 cycle with 0xDEADBEEF.
REQ-036 Stall: rdy_in low 3 cycles during WAIT -> state, ic_to_mc_pc unchanged; fill after rdy_in returns completes normally.
REQ-037 Async reset mid-WAIT: outputs zero before next clock edge; subsequent 0x100 request misses.
